wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x64 register file; it drives the register file's write, wrAddr and wrData inputs.
- Merges two result sources:
  - single-cycle ALU results: no backpressure, always highest priority;
  - variable-latency load returns: valid/ready handshake, buffered in a small FIFO.
- Provides per-register pending-write status (busyA/busyB) to the operand-read/hazard logic.

Parameters:
DATA_W, 64, width of result data (matches register file width)
DEPTH, 4, load FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
aluValid  input  1  ALU result present this cycle
aluAddr  input  5  ALU destination register
aluData  input  DATA_W  ALU result
ldValid  input  1  load return offered
ldReady  output  1  load return can be accepted
ldAddr  input  5  load destination register
ldData  input  DATA_W  load data
write  output  1  register file write enable (registered)
wrAddr  output  5  register file write address (registered)
wrData  output  DATA_W  register file write data (registered)
qAddrA  input  5  query address A (operand A read address)
qAddrB  input  5  query address B
busyA  output  1  live pending write to qAddrA exists
busyB  output  1  live pending write to qAddrB exists
fifoCount  output  $clog2(DEPTH)+1  occupied FIFO entries, including squashed ones

Behaviour:
- Reset (reset=0, async):
  - write=0, wrAddr=0, wrData=0.
  - FIFO empty, fifoCount=0, all entry live bits 0.
  - ldReady=0 while reset is low.
- ldReady = reset && (fifoCount < DEPTH). Combinational, independent of ldValid and aluValid.
- Load push: on ldValid && ldReady, write {live=1, ldAddr, ldData} at the tail. Loads always pass through the FIFO; there is no same-cycle bypass.
- Output register selection, evaluated each edge:
  1. aluValid=1: write<=1, wrAddr<=aluAddr, wrData<=aluData. ALU latency is 1 cycle.
  2. Otherwise, FIFO non-empty: pop the head. If head live=1: write<=1 with the head addr/data. If head live=0 (squashed): write<=0 and the entry is discarded.
  3. Otherwise write<=0; wrAddr and wrData hold their previous values.
- Minimum load latency is 2 edges (push, then pop). Loads stall indefinitely while aluValid stays high; the ALU is never stalled.
- Push and pop may occur in the same cycle. fifoCount changes by +1, -1 or 0 accordingly.
- When full, ldReady=0, so a same-cycle pop does not enable a push (no pass-through when full).
- Ordering / squash rule (ALU write treated as younger than every buffered load):
  - When aluValid=1, every FIFO entry with addr==aluAddr has live cleared at that edge.
  - A load pushed in the same cycle with ldAddr==aluAddr is stored with live=0.
  - Squashed entries still occupy slots until popped.
- Busy query, combinational: busyA = (write && wrAddr==qAddrA) || any live entry with addr==qAddrA. busyB is the same using qAddrB.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifoCount saturates at neither end: underflow and overflow are impossible by construction and are assertion checks.
- Reset asserted mid-operation discards all buffered loads immediately, with no writes issued.

Optional Feature:
- Macro WB_XZR_DROP_EN.
- Defined:
  - Register 31 is the hard-wired zero register.
  - aluValid with aluAddr=31 produces write<=0 at that edge, but still takes priority (no FIFO pop that cycle).
  - Loads to 31 are pushed with live=0.
  - busyA/busyB are always 0 for query address 31.
  - Squash on aluAddr=31 is still applied.
- Undefined: register 31 is treated like any other register.

Test Plan:
- Release reset, aluValid=1, aluAddr=5, aluData=0x1234 for one cycle -> next edge write=1, wrAddr=5, wrData=0x1234; following cycle write=0.
- Push 4 loads (addr 1..4, data 0xA1..0xA4) while aluValid=1 held -> ldReady=0 after the 4th, fifoCount=4, write stays driven by ALU; drop aluValid -> 4 consecutive writes addr 1..4 in order; ldReady returns 1 after the first pop.
- Push load addr 7 data 0xBEEF, then aluValid addr 7 data 0x7 before it drains -> write addr 7 = 0x7 once; popped load produces write=0; busyA (qAddrA=7) goes 1, 1, 0.
- Same-cycle ldValid addr 9 and aluValid addr 9 -> load stored squashed, only the ALU write to 9 appears.
- Assert reset=0 with fifoCount=3 mid-drain -> write=0 and fifoCount=0 immediately; no further writes after release.
- With WB_XZR_DROP_EN: aluValid addr 31, then load addr 31 -> no write=1 cycles; busyA=0 for qAddrA=31 throughout.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered load returns into the register file write port.
// Optional macro WB_XZR_DROP_EN makes register 31 a hard-wired zero register.
module wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aluValid,
  input  logic [4:0]                 aluAddr,
  input  logic [DATA_W-1:0]          aluData,
  input  logic                       ldValid,
  output logic                       ldReady,
  input  logic [4:0]                 ldAddr,
  input  logic [DATA_W-1:0]          ldData,
  output logic                       write,
  output logic [4:0]                 wrAddr,
  output logic [DATA_W-1:0]          wrData,
  input  logic [4:0]                 qAddrA,
  input  logic [4:0]                 qAddrB,
  output logic                       busyA,
  output logic                       busyB,
  output logic [$clog2(DEPTH):0]     fifoCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     head_q, tail_q;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [4:0]        addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              write_q, write_d;
  logic [4:0]        wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;

  logic push, pop;
  logic aluZero, ldZero, qZeroA, qZeroB;

`ifdef WB_XZR_DROP_EN
  assign aluZero = (aluAddr == 5'd31);
  assign ldZero  = (ldAddr  == 5'd31);
  assign qZeroA  = (qAddrA  == 5'd31);
  assign qZeroB  = (qAddrB  == 5'd31);
`else
  assign aluZero = 1'b0;
  assign ldZero  = 1'b0;
  assign qZeroA  = 1'b0;
  assign qZeroB  = 1'b0;
`endif

  assign ldReady   = reset && (count_q < CW'(DEPTH));
  assign push      = ldValid && ldReady;
  assign pop       = !aluValid && (count_q != '0);
  assign write     = write_q;
  assign wrAddr    = wrAddr_q;
  assign wrData    = wrData_q;
  assign fifoCount = count_q;

  // The ALU result is younger than every buffered load, so matching entries lose their live bit.
  always_comb begin
    write_d  = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    live_d   = live_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    if (aluValid) begin
      write_d = !aluZero;
      if (!aluZero) begin
        wrAddr_d = aluAddr;
        wrData_d = aluData;
      end
    end else if (pop && live_q[head_q]) begin
      write_d  = 1'b1;
      wrAddr_d = addr_q[head_q];
      wrData_d = data_q[head_q];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (aluValid && (addr_q[i] == aluAddr)) live_d[i] = 1'b0;
    end
    if (pop) live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = !(aluValid && (ldAddr == aluAddr)) && !ldZero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      live_q   <= '0;
      write_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      count_q  <= count_d;
      live_q   <= live_d;
      write_q  <= write_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Payload storage needs no reset: a slot is only read when its live bit or occupancy says so.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= ldAddr;
      data_q[tail_q] <= ldData;
    end
  end

  always_comb begin
    busyA = write_q && (wrAddr_q == qAddrA);
    busyB = write_q && (wrAddr_q == qAddrB);
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == qAddrA)) busyA = 1'b1;
      if (live_q[i] && (addr_q[i] == qAddrB)) busyB = 1'b1;
    end
    if (qZeroA) busyA = 1'b0;
    if (qZeroB) busyB = 1'b0;
  end

  a_noOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count_q == CW'(DEPTH))));
  a_noUnderflow: assert property (@(posedge clk) disable iff (!reset)
    !(pop && (count_q == '0)));
  a_countBound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
// Register-31 checks run only when WB_XZR_DROP_EN is defined.
module tb_wb_arbiter;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              aluValid;
  logic [4:0]        aluAddr;
  logic [DATA_W-1:0] aluData;
  logic              ldValid;
  logic              ldReady;
  logic [4:0]        ldAddr;
  logic [DATA_W-1:0] ldData;
  logic              write;
  logic [4:0]        wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [4:0]        qAddrA;
  logic [4:0]        qAddrB;
  logic              busyA;
  logic              busyB;
  logic [2:0]        fifoCount;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData),
    .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .qAddrA(qAddrA), .qAddrB(qAddrB), .busyA(busyA), .busyB(busyB),
    .fifoCount(fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [4:0] aA, input logic [63:0] aD,
                               input logic lV, input logic [4:0] lA, input logic [63:0] lD);
    aluValid = aV;
    aluAddr  = aA;
    aluData  = aD;
    ldValid  = lV;
    ldAddr   = lA;
    ldData   = lD;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    qAddrA = 5'd0;
    qAddrB = 5'd0;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #12;
    checkOutput("rst_write", write, 1'b0);
    checkOutput("rst_wrAddr", wrAddr, 5'd0);
    checkOutput("rst_wrData", wrData, 64'h0);
    checkOutput("rst_count", fifoCount, 3'd0);
    checkOutput("rst_ldReady", ldReady, 1'b0);

    $display("[TB] single ALU write");
    reset = 1'b1;
    #1;
    checkOutput("ready_after_rst", ldReady, 1'b1);
    applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("alu_write", write, 1'b1);
    checkOutput("alu_wrAddr", wrAddr, 5'd5);
    checkOutput("alu_wrData", wrData, 64'h1234);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("alu_idle_write", write, 1'b0);
    checkOutput("alu_idle_hold", wrAddr, 5'd5);

    $display("[TB] fill FIFO under ALU priority");
    qAddrA = 5'd3;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(16 + k), 64'(k), 1'b1, 5'(k), 64'(8'hA0 + k));
      tick();
      checkOutput("fill_alu_write", write, 1'b1);
      checkOutput("fill_alu_addr", wrAddr, 64'(16 + k));
      checkOutput("fill_count", fifoCount, 64'(k));
    end
    checkOutput("full_ldReady", ldReady, 1'b0);
    checkOutput("full_busyA", busyA, 1'b1);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("drain_write", write, 1'b1);
      checkOutput("drain_addr", wrAddr, 64'(k));
      checkOutput("drain_data", wrData, 64'(8'hA0 + k));
      checkOutput("drain_count", fifoCount, 64'(4 - k));
      checkOutput("drain_ldReady", ldReady, 1'b1);
    end
    tick();
    checkOutput("drain_done_write", write, 1'b0);
    checkOutput("drain_done_busyA", busyA, 1'b0);

    $display("[TB] ALU squashes older load");
    qAddrA = 5'd7;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hBEEF);
    tick();
    checkOutput("sq_push_count", fifoCount, 3'd1);
    checkOutput("sq_push_write", write, 1'b0);
    checkOutput("sq_busy0", busyA, 1'b1);
    applyStimulus(1'b1, 5'd7, 64'h7, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("sq_alu_write", write, 1'b1);
    checkOutput("sq_alu_addr", wrAddr, 5'd7);
    checkOutput("sq_alu_data", wrData, 64'h7);
    checkOutput("sq_alu_count", fifoCount, 3'd1);
    checkOutput("sq_busy1", busyA, 1'b1);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("sq_pop_write", write, 1'b0);
    checkOutput("sq_pop_count", fifoCount, 3'd0);
    checkOutput("sq_busy2", busyA, 1'b0);

    $display("[TB] same-cycle load and ALU to same register");
    qAddrB = 5'd9;
    applyStimulus(1'b1, 5'd9, 64'h9, 1'b1, 5'd9, 64'h99);
    tick();
    checkOutput("same_write", write, 1'b1);
    checkOutput("same_addr", wrAddr, 5'd9);
    checkOutput("same_data", wrData, 64'h9);
    checkOutput("same_count", fifoCount, 3'd1);
    checkOutput("same_busyB", busyB, 1'b1);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("same_pop_write", write, 1'b0);
    checkOutput("same_pop_count", fifoCount, 3'd0);
    checkOutput("same_pop_busyB", busyB, 1'b0);

    $display("[TB] reset mid-drain");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'd20, 64'h20, 1'b1, 5'(k), 64'(8'hC0 + k));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("mid_write", write, 1'b1);
    checkOutput("mid_addr", wrAddr, 5'd1);
    checkOutput("mid_count", fifoCount, 3'd3);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_write", write, 1'b0);
    checkOutput("mid_rst_count", fifoCount, 3'd0);
    checkOutput("mid_rst_ldReady", ldReady, 1'b0);
    checkOutput("mid_rst_wrAddr", wrAddr, 5'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("post_rst_write", write, 1'b0);
      checkOutput("post_rst_count", fifoCount, 3'd0);
    end

`ifdef WB_XZR_DROP_EN
    $display("[TB] zero register drop");
    qAddrA = 5'd31;
    applyStimulus(1'b1, 5'd31, 64'h31, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("xzr_alu_write", write, 1'b0);
    checkOutput("xzr_alu_busyA", busyA, 1'b0);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'h3131);
    tick();
    checkOutput("xzr_ld_write", write, 1'b0);
    checkOutput("xzr_ld_count", fifoCount, 3'd1);
    checkOutput("xzr_ld_busyA", busyA, 1'b0);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();
    checkOutput("xzr_pop_write", write, 1'b0);
    checkOutput("xzr_pop_count", fifoCount, 3'd0);
    checkOutput("xzr_pop_busyA", busyA, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
